// File: rtl/result_drain_ctrl.sv
// result_drain_ctrl
//   Drains the N x N result RAM banks to the host over UART once the array
//   signals completion. Walks address 0..num_words-1 and, at each address, the
//   banks in row-major order. Each 32-bit word is sent as 4 bytes, MSB first.
//   The C-RAM read port and the UART TX handshake belong to this block while
//   busy is high.
//
//   Optional feature macro: DRAIN_CSUM_EN
//     When defined, one checksum byte is appended after the last data byte.
//     The checksum is the XOR of every data byte, cleared on each accepted
//     start. A zero-word drain sends a single 0x00 checksum byte.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   start          in   1-cycle pulse; accepted only when idle
//   num_words      in   words per bank, sampled on accepted start (clamped)
//   ram_c_q        in   bank b read data at [b*32 +: 32]
//   uart_tx_done   in   1-cycle pulse: current byte has left the transmitter
//   ram_c_addr     out  read address shared by all banks (held between reads)
//   ram_c_rden     out  one-hot read enable, bank b at bit b
//   uart_send_data out  1-cycle pulse: transmit uart_tx_data
//   uart_tx_data   out  byte to transmit, stable until uart_tx_done
//   busy           out  high from accepted start until done
//   done           out  1-cycle pulse after the final byte completes
module result_drain_ctrl #(
  parameter int N      = 2,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     num_words,
  input  logic [N*N*32-1:0]   ram_c_q,
  input  logic                uart_tx_done,
  output logic [ADDR_W-1:0]   ram_c_addr,
  output logic [N*N-1:0]      ram_c_rden,
  output logic                uart_send_data,
  output logic [7:0]          uart_tx_data,
  output logic                busy,
  output logic                done
);

  localparam int                NB        = N * N;
  localparam int                BANK_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NB - 1);
  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_LOAD,
    S_SEND,
    S_WAIT_TX,
    S_NEXT,
    S_FIN
  } state_t;

  state_t              r_state;
  logic [ADDR_W:0]     r_nw;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [BANK_W-1:0]   r_bank;
  logic [1:0]          r_byte_idx;
  logic [1:0]          r_wait;
  logic [31:0]         r_shreg;
  logic [NB-1:0]       r_rden;
  logic                r_send;
  logic [7:0]          r_tx_data;
  logic                r_busy;
  logic                r_done;
`ifdef DRAIN_CSUM_EN
  logic [7:0]          r_csum;
  logic                r_csum_phase;
`endif

  logic [31:0]         w_q [NB];
  logic [ADDR_W:0]     w_nw_clamped;
  logic                w_last_word;

  always_comb begin
    for (int unsigned b = 0; b < NB; b++) begin
      w_q[b] = ram_c_q[b*32 +: 32];
    end
  end

  // Clamping keeps the address counter from ever wrapping within one drain.
  assign w_nw_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign w_last_word  = ({1'b0, r_addr} == (r_nw - (ADDR_W+1)'(1))) &&
                        (r_bank == LAST_BANK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_nw       <= '0;
      r_addr     <= '0;
      r_ram_addr <= '0;
      r_bank     <= '0;
      r_byte_idx <= '0;
      r_wait     <= '0;
      r_shreg    <= '0;
      r_rden     <= '0;
      r_send     <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DRAIN_CSUM_EN
      r_csum       <= '0;
      r_csum_phase <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_send <= 1'b0;
      r_rden <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nw   <= w_nw_clamped;
            r_addr <= '0;
            r_bank <= '0;
            r_busy <= 1'b1;
`ifdef DRAIN_CSUM_EN
            r_csum       <= '0;
            r_csum_phase <= 1'b0;
`endif
            if (num_words == '0) begin
`ifdef DRAIN_CSUM_EN
              // Empty drain still emits the (zero) checksum byte.
              r_shreg      <= '0;
              r_csum_phase <= 1'b1;
              r_state      <= S_SEND;
`else
              r_state <= S_FIN;
`endif
            end else begin
              r_state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          r_ram_addr <= r_addr;
          r_rden     <= NB'(1) << r_bank;
          r_wait     <= '0;
          r_state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_state <= S_LOAD;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_LOAD: begin
          r_shreg    <= w_q[r_bank];
          r_byte_idx <= '0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          r_send    <= 1'b1;
          r_tx_data <= r_shreg[31:24];
`ifdef DRAIN_CSUM_EN
          if (!r_csum_phase) begin
            r_csum <= r_csum ^ r_shreg[31:24];
          end
`endif
          r_state <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (uart_tx_done) begin
            r_shreg    <= r_shreg << 8;
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef DRAIN_CSUM_EN
            if (r_csum_phase) begin
              r_state <= S_FIN;
            end else
`endif
            if (r_byte_idx == 2'd3) begin
              r_state <= S_NEXT;
            end else begin
              r_state <= S_SEND;
            end
          end
        end
        S_NEXT: begin
          if (w_last_word) begin
`ifdef DRAIN_CSUM_EN
            r_shreg      <= {r_csum, 24'h0};
            r_csum_phase <= 1'b1;
            r_state      <= S_SEND;
`else
            r_state <= S_FIN;
`endif
          end else begin
            if (r_bank == LAST_BANK) begin
              r_bank <= '0;
              r_addr <= r_addr + ADDR_W'(1);
            end else begin
              r_bank <= r_bank + BANK_W'(1);
            end
            r_state <= S_RD_REQ;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_c_addr     = r_ram_addr;
  assign ram_c_rden     = r_rden;
  assign uart_send_data = r_send;
  assign uart_tx_data   = r_tx_data;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Self-checking bench for result_drain_ctrl (N=2, small ADDR_W so the
// num_words clamp boundary is reachable). A behavioural RAM and UART responder
// drive the DUT; expected byte and read sequences come from a flat model of
// the drain order built from the RAM contents.
module tb_result_drain_ctrl;

  localparam int N      = 2;
  localparam int ADDR_W = 3;
  localparam int RD_LAT = 1;
  localparam int NB     = N * N;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ADDR_W:0]     num_words;
  logic [NB*32-1:0]    ram_c_q = '0;
  logic                uart_tx_done;
  logic [ADDR_W-1:0]   ram_c_addr;
  logic [NB-1:0]       ram_c_rden;
  logic                uart_send_data;
  logic [7:0]          uart_tx_data;
  logic                busy;
  logic                done;

  result_drain_ctrl #(.N(N), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .ram_c_q(ram_c_q), .uart_tx_done(uart_tx_done), .ram_c_addr(ram_c_addr),
    .ram_c_rden(ram_c_rden), .uart_send_data(uart_send_data),
    .uart_tx_data(uart_tx_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [NB][DEPTH];

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_c_rden[b]) ram_c_q[b*32 +: 32] <= mem[b][ram_c_addr];
    end
  end

  // UART responder: tx_done a programmable number of cycles after each send.
  int tx_delay_min = 20;
  int tx_delay_max = 20;
  bit spur_en      = 1'b0;

  initial begin
    int cnt;
    bit pend;
    uart_tx_done = 1'b0;
    pend = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      uart_tx_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          uart_tx_done = 1'b1;
          pend = 1'b0;
        end
      end else if (uart_send_data) begin
        pend = 1'b1;
        cnt  = $urandom_range(tx_delay_min, tx_delay_max);
      end else if (spur_en && (ram_c_rden != '0)) begin
        uart_tx_done = 1'b1;
      end
    end
  end

  // Observation: records bytes, reads, done pulses and protocol violations.
  logic [7:0] got_bytes[$];
  int         got_rd[$];
  int         send_cnt  = 0;
  int         done_cnt  = 0;
  int         proto_err = 0;
  bit         outstanding = 1'b0;
  logic [7:0] held;

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (outstanding && uart_tx_data !== held) proto_err++;
      if (uart_tx_done) outstanding = 1'b0;
      if (uart_send_data) begin
        if (outstanding) proto_err++;
        outstanding = 1'b1;
        held = uart_tx_data;
        got_bytes.push_back(uart_tx_data);
        send_cnt++;
      end
      if (ram_c_rden != '0) begin
        if (!$onehot(ram_c_rden) || !busy) proto_err++;
        for (int b = 0; b < NB; b++) begin
          if (ram_c_rden[b]) got_rd.push_back(int'(ram_c_addr) * NB + b);
        end
      end
      if (done) done_cnt++;
    end
  end

  // Reference model: drain order is address-major, bank-minor, MSB byte first.
  logic [7:0] exp_bytes[$];
  int         exp_rd[$];

  function automatic void build_expect(input int nw);
    int eff;
    logic [7:0] cs;
    logic [31:0] w;
    eff = (nw > DEPTH) ? DEPTH : nw;
    exp_bytes.delete();
    exp_rd.delete();
    cs = 8'h00;
    for (int a = 0; a < eff; a++) begin
      for (int b = 0; b < NB; b++) begin
        exp_rd.push_back(a * NB + b);
        w = mem[b][a];
        for (int k = 3; k >= 0; k--) begin
          exp_bytes.push_back(w[k*8 +: 8]);
          cs = cs ^ w[k*8 +: 8];
        end
      end
    end
`ifdef DRAIN_CSUM_EN
    exp_bytes.push_back(cs);
`endif
  endfunction

  task automatic fill_random();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mem[b][a] = $urandom;
  endtask

  task automatic clear_logs();
    got_bytes.delete();
    got_rd.delete();
    send_cnt  = 0;
    done_cnt  = 0;
    proto_err = 0;
  endtask

  // Starts one drain and waits (bounded) for its done pulse.
  task automatic run_drain(input int nw, input int budget, output bit timed_out);
    int cyc;
    clear_logs();
    @(negedge clk);
    num_words = nw[ADDR_W:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_words = ADDR_W'($urandom);
    cyc = 0;
    timed_out = 1'b0;
    while (done_cnt == 0 && !timed_out) begin
      @(negedge clk);
      cyc++;
      if (cyc > budget) timed_out = 1'b1;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    bit to;
    rst = 1'b1; start = 1'b0; num_words = '0;
    tx_delay_min = 3; tx_delay_max = 3;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, uart_send_data} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, uart_send_data});
    end
    n_checks++;
    if ({ram_c_rden, ram_c_addr, uart_tx_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: rden %b addr %0h data %0h expected all 0", ram_c_rden, ram_c_addr, uart_tx_data);
    end
    rst = 1'b0;
    fill_random();
    clear_logs();
    @(negedge clk);
    num_words = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy_mid: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, uart_send_data, ram_c_rden} !== '0) begin
      n_fail++; $display("FAIL reset_abort: busy %b done %b send %b rden %b expected all 0", busy, done, uart_send_data, ram_c_rden);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_done: done pulses %0d busy %b expected 0 0", done_cnt, busy);
    end
    fill_random();
    build_expect(1);
    run_drain(1, 20000, to);
    n_checks++;
    if (to || done_cnt !== 1) begin
      n_fail++; $display("FAIL reset_restart: timeout %b done pulses %0d expected 0 1", to, done_cnt);
    end
    n_checks++;
    if (got_bytes != exp_bytes) begin
      n_fail++; $display("FAIL reset_restart_bytes: got %0d bytes expected %0d (contents differ)", got_bytes.size(), exp_bytes.size());
    end
  endtask

  task automatic test_single_word();
    bit to;
    logic [31:0] pat [2][NB];
    pat[0][0] = 32'h11223344; pat[0][1] = 32'h55667788;
    pat[0][2] = 32'h99AABBCC; pat[0][3] = 32'hDDEEFF00;
    pat[1][0] = 32'h01000000; pat[1][1] = 32'h0;
    pat[1][2] = 32'h0;        pat[1][3] = 32'h0;
    tx_delay_min = 20; tx_delay_max = 20;
    for (int p = 0; p < 2; p++) begin
      fill_random();
      for (int b = 0; b < NB; b++) mem[b][0] = pat[p][b];
      build_expect(1);
      run_drain(1, 20000, to);
      n_checks++;
      if (to || done_cnt !== 1) begin
        n_fail++; $display("FAIL single_done: pattern %0d timeout %b done pulses %0d expected 0 1", p, to, done_cnt);
      end
      n_checks++;
      if (send_cnt !== exp_bytes.size()) begin
        n_fail++; $display("FAIL single_sends: pattern %0d got %0d expected %0d", p, send_cnt, exp_bytes.size());
      end
      for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
        n_checks++;
        if (got_bytes[i] !== exp_bytes[i]) begin
          n_fail++; $display("FAIL single_byte[%0d]: pattern %0d got %02h expected %02h", i, p, got_bytes[i], exp_bytes[i]);
        end
      end
      n_checks++;
      if (busy !== 1'b0 || proto_err !== 0) begin
        n_fail++; $display("FAIL single_idle: busy %b protocol errors %0d expected 0 0", busy, proto_err);
      end
    end
  endtask

  task automatic test_zero_words();
    int cyc;
    bit seen;
    logic busy_c1;
    tx_delay_min = 4; tx_delay_max = 4;
    build_expect(0);
    clear_logs();
    @(negedge clk);
    num_words = '0; start = 1'b1;
    cyc = 0; seen = 1'b0; busy_c1 = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        busy_c1 = busy;
      end
      if (done) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (!seen || busy_c1 !== 1'b1) begin
      n_fail++; $display("FAIL zero_done: done seen %b busy after start %b expected 1 1", seen, busy_c1);
    end
`ifndef DRAIN_CSUM_EN
    n_checks++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL zero_latency: done after %0d cycles expected 2", cyc);
    end
`endif
    n_checks++;
    if (got_bytes != exp_bytes || got_rd.size() !== 0) begin
      n_fail++; $display("FAIL zero_bytes: got %0d bytes %0d reads expected %0d bytes 0 reads", got_bytes.size(), got_rd.size(), exp_bytes.size());
    end
  endtask

  task automatic test_multi_word();
    bit to;
    tx_delay_min = 1; tx_delay_max = 6;
    fill_random();
    build_expect(3);
    run_drain(3, 20000, to);
    n_checks++;
    if (to || done_cnt !== 1 || proto_err !== 0) begin
      n_fail++; $display("FAIL multi_done: timeout %b done %0d protocol errors %0d expected 0 1 0", to, done_cnt, proto_err);
    end
    n_checks++;
    if (got_rd.size() !== exp_rd.size()) begin
      n_fail++; $display("FAIL multi_reads: got %0d expected %0d", got_rd.size(), exp_rd.size());
    end
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
      n_checks++;
      if (got_rd[i] !== exp_rd[i]) begin
        n_fail++; $display("FAIL multi_read[%0d]: got addr*NB+bank %0d expected %0d", i, got_rd[i], exp_rd[i]);
      end
    end
    n_checks++;
    if (got_bytes.size() !== exp_bytes.size()) begin
      n_fail++; $display("FAIL multi_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL multi_byte[%0d]: got %02h expected %02h", i, got_bytes[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_ignore();
    int cyc;
    tx_delay_min = 2; tx_delay_max = 5;
    fill_random();
    build_expect(2);
    clear_logs();
    spur_en = 1'b1;
    @(negedge clk);
    num_words = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = ($urandom_range(0, 15) == 0);
      if (start) num_words = ($urandom_range(0, 1) == 0) ? '0 : 4'd7;
    end
    start = 1'b0;
    spur_en = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt !== 1 || busy !== 1'b0 || proto_err !== 0) begin
      n_fail++; $display("FAIL ignore_done: done %0d busy %b protocol errors %0d expected 1 0 0", done_cnt, busy, proto_err);
    end
    n_checks++;
    if (got_rd != exp_rd) begin
      n_fail++; $display("FAIL ignore_reads: got %0d reads expected %0d (sequence differs)", got_rd.size(), exp_rd.size());
    end
    n_checks++;
    if (got_bytes != exp_bytes) begin
      n_fail++; $display("FAIL ignore_bytes: got %0d bytes expected %0d (contents differ)", got_bytes.size(), exp_bytes.size());
    end
  endtask

  task automatic test_boundary();
    bit to;
    int nws [3];
    nws[0] = DEPTH; nws[1] = DEPTH + 4; nws[2] = 2 * DEPTH - 1;
    tx_delay_min = 1; tx_delay_max = 2;
    for (int k = 0; k < 3; k++) begin
      fill_random();
      build_expect(nws[k]);
      run_drain(nws[k], 20000, to);
      n_checks++;
      if (to || done_cnt !== 1 || proto_err !== 0) begin
        n_fail++; $display("FAIL clamp_done: nw %0d timeout %b done %0d protocol errors %0d", nws[k], to, done_cnt, proto_err);
      end
      n_checks++;
      if (got_rd != exp_rd) begin
        n_fail++; $display("FAIL clamp_reads: nw %0d got %0d reads expected %0d", nws[k], got_rd.size(), exp_rd.size());
      end
      n_checks++;
      if (got_bytes != exp_bytes) begin
        n_fail++; $display("FAIL clamp_bytes: nw %0d got %0d bytes expected %0d", nws[k], got_bytes.size(), exp_bytes.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int nw;
    tx_delay_min = 1; tx_delay_max = 8;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      nw = $urandom_range(1, 4);
      build_expect(nw);
      run_drain(nw, 20000, to);
      n_checks++;
      if (to || done_cnt !== 1 || proto_err !== 0) begin
        n_fail++; $display("FAIL b2b_done: iter %0d timeout %b done %0d protocol errors %0d", it, to, done_cnt, proto_err);
      end
      n_checks++;
      if (got_bytes != exp_bytes || got_rd != exp_rd) begin
        n_fail++; $display("FAIL b2b_stream: iter %0d nw %0d got %0d bytes/%0d reads expected %0d/%0d", it, nw, got_bytes.size(), got_rd.size(), exp_bytes.size(), exp_rd.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_words = '0;
    test_reset();
    test_single_word();
    test_zero_words();
    test_multi_word();
    test_ignore();
    test_boundary();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
